// File: rtl/avg_seg_display.sv
// Sequential binary-to-BCD converter for an 8-bit average feeding a
// three-digit multiplexed seven-segment display with leading-zero blanking.
//
// state  | meaning
// IDLE   | no conversion in flight, pending buffer empty
// SHIFT  | double-dabble iterations, one input bit per cycle
// COMMIT | BCD result copied to display, next conversion chosen
module avg_seg_display #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] avg_in,
  input  logic       avg_valid,
  output logic [6:0] seg,
  output logic [2:0] digit_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [11:0] bcd, bcd_nxt, bcd_adj;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  pend, pend_nxt;
  logic        pend_full, pend_full_nxt;
  logic        commit;

  logic [11:0] dig, dig_nxt;
  logic [15:0] scan_cnt, scan_cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        scan_tc;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_nxt;
  logic [2:0]  sel_nxt;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bcd_nxt       = bcd;
    bit_cnt_nxt   = bit_cnt;
    pend_nxt      = pend;
    pend_full_nxt = pend_full;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        if (avg_valid) begin
          shreg_nxt   = avg_in;
          bcd_nxt     = 12'd0;
          bit_cnt_nxt = 3'd0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_nxt     = {bcd_adj[10:0], shreg[7]};
        shreg_nxt   = {shreg[6:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = COMMIT;
        // newest strobe wins; the running conversion is never disturbed
        if (avg_valid) begin
          pend_nxt      = avg_in;
          pend_full_nxt = 1'b1;
        end
      end
      COMMIT: begin
        commit      = 1'b1;
        bcd_nxt     = 12'd0;
        bit_cnt_nxt = 3'd0;
        if (avg_valid) begin
          shreg_nxt     = avg_in;
          pend_full_nxt = 1'b0;
          state_nxt     = SHIFT;
        end else if (pend_full) begin
          shreg_nxt     = pend;
          pend_full_nxt = 1'b0;
          state_nxt     = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display path is computed from next-state values so seg and digit_sel
  // register together and a committed value shows up right after COMMIT.
  always_comb begin
    dig_nxt      = commit ? bcd : dig;
    scan_tc      = (scan_cnt == SCAN_TC);
    scan_cnt_nxt = scan_tc ? 16'd0 : scan_cnt + 16'd1;
    idx_nxt      = idx;
    if (scan_tc) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    nib     = dig_nxt[3:0];
    blank   = 1'b0;
    sel_nxt = 3'b001;
    case (idx_nxt)
      2'd1: begin
        nib     = dig_nxt[7:4];
        blank   = BLANK_LZ && (dig_nxt[11:8] == 4'd0) && (dig_nxt[7:4] == 4'd0);
        sel_nxt = 3'b010;
      end
      2'd2: begin
        nib     = dig_nxt[11:8];
        blank   = BLANK_LZ && (dig_nxt[11:8] == 4'd0);
        sel_nxt = 3'b100;
      end
      default: ;
    endcase
    seg_nxt = blank ? 7'h00 : decode(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= 8'd0;
      bcd       <= 12'd0;
      bit_cnt   <= 3'd0;
      pend      <= 8'd0;
      pend_full <= 1'b0;
      dig       <= 12'd0;
      scan_cnt  <= 16'd0;
      idx       <= 2'd0;
      seg       <= 7'h3F;
      digit_sel <= 3'b001;
    end else begin
      shreg     <= shreg_nxt;
      bcd       <= bcd_nxt;
      bit_cnt   <= bit_cnt_nxt;
      pend      <= pend_nxt;
      pend_full <= pend_full_nxt;
      dig       <= dig_nxt;
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      seg       <= seg_nxt;
      digit_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_avg_seg_display.sv
// Directed bench: three instances share stimulus (slow scan, fast scan with
// blanking, fast scan without blanking); expected segments are hand-decoded.
module tb_avg_seg_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] avg_in;
  logic       avg_valid;

  logic [6:0] seg_s, seg_f, seg_n;
  logic [2:0] sel_s, sel_f, sel_n;
  logic       busy_s, busy_f, busy_n;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  avg_seg_display #(.SCAN_DIV(3), .BLANK_LZ(1'b1)) u_scan3 (
    .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
    .seg(seg_s), .digit_sel(sel_s), .busy(busy_s));

  avg_seg_display #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u_fast (
    .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
    .seg(seg_f), .digit_sel(sel_f), .busy(busy_f));

  avg_seg_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u_nolz (
    .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
    .seg(seg_n), .digit_sel(sel_n), .busy(busy_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic exp_busy, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {31'd0, busy_f}, {31'd0, exp_busy});
    end
  endtask

  task automatic strobe(input logic [7:0] v, input string tag);
    avg_in    = v;
    avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    chk(tag, {31'd0, busy_f}, 32'd1);
  endtask

  // Samples three consecutive cycles of the fast-scan instances (one per digit).
  task automatic check_digits(input string tag,
                              input logic [6:0] eo, input logic [6:0] et, input logic [6:0] eh,
                              input logic [6:0] no, input logic [6:0] nt, input logic [6:0] nh);
    logic [7:0] o, t, h, o2, t2, h2;
    o = 8'hFF; t = 8'hFF; h = 8'hFF; o2 = 8'hFF; t2 = 8'hFF; h2 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      case (sel_f)
        3'b001: begin o = {1'b0, seg_f}; o2 = {1'b0, seg_n}; end
        3'b010: begin t = {1'b0, seg_f}; t2 = {1'b0, seg_n}; end
        3'b100: begin h = {1'b0, seg_f}; h2 = {1'b0, seg_n}; end
        default: ;
      endcase
    end
    chk({tag, "_ones"},      {24'd0, o},  {25'd0, eo});
    chk({tag, "_tens"},      {24'd0, t},  {25'd0, et});
    chk({tag, "_hund"},      {24'd0, h},  {25'd0, eh});
    chk({tag, "_ones_nolz"}, {24'd0, o2}, {25'd0, no});
    chk({tag, "_tens_nolz"}, {24'd0, t2}, {25'd0, nt});
    chk({tag, "_hund_nolz"}, {24'd0, h2}, {25'd0, nh});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; avg_valid = 1'b0; avg_in = 8'd0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("scan3_sel", {29'd0, sel_s}, 32'd1 << ((k / 3) % 3));
      chk("scan3_seg", {25'd0, seg_s}, ((k / 3) % 3 == 0) ? 32'h3F : 32'h00);
      tick();
    end

    // 255: busy after edges 0..8, idle after edge 9
    strobe(8'd255, "b255_e0");
    run(8, 1'b1, "b255_shift");
    run(1, 1'b0, "b255_done");
    check_digits("v255", 7'h6D, 7'h6D, 7'h5B, 7'h6D, 7'h6D, 7'h5B);

    strobe(8'd7, "b7_e0");
    run(8, 1'b1, "b7_shift");
    run(1, 1'b0, "b7_done");
    check_digits("v7", 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);

    // 100 at edge 0, 42 at edge 3, 99 at edge 5: 42 is overwritten
    strobe(8'd100, "p_e0");
    run(2, 1'b1, "p_e12");
    avg_in = 8'd42; avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    chk("p_e3", {31'd0, busy_f}, 32'd1);
    run(1, 1'b1, "p_e4");
    avg_in = 8'd99; avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    chk("p_e5", {31'd0, busy_f}, 32'd1);
    run(4, 1'b1, "p_e6_9");
    check_digits("v100", 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h06);
    run(6, 1'b1, "p_e12_17");
    run(1, 1'b0, "p_e18");
    check_digits("v99", 7'h6F, 7'h6F, 7'h00, 7'h6F, 7'h6F, 7'h3F);

    // second strobe lands exactly in the COMMIT cycle
    strobe(8'd10, "c_e0");
    run(8, 1'b1, "c_shift");
    avg_in = 8'd250; avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    chk("c_e9", {31'd0, busy_f}, 32'd1);
    check_digits("v10", 7'h3F, 7'h06, 7'h00, 7'h3F, 7'h06, 7'h3F);
    run(6, 1'b1, "c_e12_17");
    run(1, 1'b0, "c_e18");
    check_digits("v250", 7'h3F, 7'h6D, 7'h5B, 7'h3F, 7'h6D, 7'h5B);

    // reset mid-conversion discards 200
    strobe(8'd200, "r_e0");
    run(3, 1'b1, "r_e1_3");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_e4_busy", {31'd0, busy_f}, 32'd0);
    run(12, 1'b0, "r_idle");
    check_digits("vrst", 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F);

    // reset wins over a simultaneous strobe
    strobe(8'd123, "q_e0");
    run(8, 1'b1, "q_shift");
    run(1, 1'b0, "q_done");
    check_digits("v123", 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
    rst = 1'b1; avg_valid = 1'b1; avg_in = 8'd55;
    tick();
    rst = 1'b0; avg_valid = 1'b0;
    chk("prio_busy", {31'd0, busy_f}, 32'd0);
    run(10, 1'b0, "prio_idle");
    check_digits("vprio", 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/avg_seg_display.md
AVG_SEG_DISPLAY -- requirements
Module: avg_seg_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each digit is driven; legal range 1..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = always show three digits.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 avg_in  input  8  unsigned moving-average result from the averager stage.
REQ-006 avg_valid  input  1  one-cycle strobe; avg_in is valid while it is high.
REQ-007 seg  output  7  active-high segments {g,f,e,d,c,b,a}; bit0 = a.
REQ-008 digit_sel  output  3  one-hot active-high digit enable: 001 ones, 010 tens, 100 hundreds.
REQ-009 busy  output  1  high while a binary-to-BCD conversion or commit is in progress.

Function
REQ-010 Conversion SHALL use sequential shift-and-add-3 (double dabble): 8 shift cycles, one bit per cycle, 12-bit BCD result.
REQ-011 FSM states SHALL be IDLE, SHIFT and COMMIT; busy = (state != IDLE).
REQ-012 IDLE with avg_valid=1 on edge 0: capture avg_in, clear BCD accumulator, enter SHIFT with bit counter 0.
REQ-013 SHIFT: on edges 1..8, add 3 to each BCD nibble >= 5, then shift left one bit; after edge 8, enter COMMIT.
REQ-014 COMMIT, edge 9: copy BCD into three display digit registers; the new value SHALL be visible on seg from the cycle after edge 9.
REQ-015 One-deep pending buffer: avg_valid during SHIFT stores avg_in; a later strobe overwrites it (newest wins).
REQ-016 COMMIT exit: if avg_valid=1 in that cycle, load avg_in directly into SHIFT and clear pending; else, if pending is full, load pending into SHIFT and clear it; else go to IDLE.
REQ-017 Pending SHALL always be empty in IDLE; conversion is never aborted by a new strobe.
REQ-018 Scan prescaler SHALL count 0..SCAN_DIV-1; on terminal count it wraps to 0 and the digit index advances ones -> tens -> hundreds -> ones.
REQ-019 SCAN_DIV=1: digit index SHALL advance every cycle.
REQ-020 Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); blank = 00.
REQ-021 BLANK_LZ=1: hundreds blank when 0; tens blank when hundreds=0 and tens=0; ones never blank.
REQ-022 seg and digit_sel SHALL be registered outputs and change in the same cycle, so digit_sel never selects a digit showing another digit's pattern.
REQ-023 Display registers SHALL change only at COMMIT; scanning is independent of conversion activity.

Reset
REQ-024 rst=1 SHALL on the next edge force state IDLE, pending empty, BCD and display digits 0, prescaler 0, digit index ones.
REQ-025 Post-reset outputs: busy=0, digit_sel=001, seg=3F; other digits blank (BLANK_LZ=1) or 3F (BLANK_LZ=0).
REQ-026 rst asserted mid-conversion SHALL abort it; the in-flight value and pending value SHALL never be displayed.
REQ-027 rst has priority over avg_valid in the same cycle.

Verification
REQ-028 Reset, SCAN_DIV=3 -> busy=0; digit_sel 001,010,100,001 changing every 3 cycles; seg 3F,00,00.
REQ-029 avg_in=255, one-cycle strobe -> busy high for 9 cycles; then ones=6D, tens=6D, hundreds=5B.
REQ-030 avg_in=7, BLANK_LZ=1 -> ones=07, tens=00, hundreds=00; with BLANK_LZ=0 -> tens=3F, hundreds=3F.
REQ-031 Strobe 100 at edge 0, 42 at edge 3, 99 at edge 5 -> 100 committed at edge 9, 99 committed at edge 18, 42 never shown, busy continuous edges 0..18.
REQ-032 Strobe 200 at edge 0, rst at edge 4 -> busy=0 after edge 4; display 0 thereafter; 200 never shown.
REQ-033 Strobe 10, with a second strobe 250 held in the COMMIT cycle -> 10 committed, then 250 committed 9 edges later.
